// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared cache request type and data-cache port arbiter state enum
package rv32i_types;

    // One UFP request to the cache: a read when ufp_rmask != 0, a write when ufp_wmask != 0.
    typedef struct packed {
        logic [31:0] ufp_addr;
        logic [3:0]  ufp_rmask;
        logic [3:0]  ufp_wmask;
        logic [31:0] ufp_wdata;
    } cache_interface_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ST_BUSY  = 2'd1,
        LD_BUSY  = 2'd2,
        LD_DRAIN = 2'd3
    } dcache_arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - shares the data cache UFP port between store queue and load unit
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           branch-mispredict recovery pulse
//   st_req, ld_req  store-queue / load-unit requests, held until their response
//   dc_ufp_resp     cache completion pulse, dc_ufp_rdata valid with it
//   dc_ufp_out      request presented to the cache
//   st_resp         store completion
//   ld_resp         load completion, ld_rdata carries the data (0 otherwise)
//   busy            an access is outstanding
module dcache_port_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  cache_interface_t st_req,
    input  cache_interface_t ld_req,
    input  logic             dc_ufp_resp,
    input  logic [31:0]      dc_ufp_rdata,
    output cache_interface_t dc_ufp_out,
    output logic             st_resp,
    output logic             ld_resp,
    output logic [31:0]      ld_rdata,
    output logic             busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    dcache_arb_state_t state, state_next;
    cache_interface_t  req_q;
    logic [CNT_W-1:0]  starve_cnt;

    logic st_valid;
    logic ld_valid;
    logic grant_st;
    logic grant_ld;

    assign st_valid = |st_req.ufp_wmask;
    assign ld_valid = |ld_req.ufp_rmask;

    // Store wins by default; the load only wins when it has starved long
    // enough or there is no store, and never in a flush cycle since the
    // load may be on the squashed path.
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (state == IDLE) begin
            if (ld_valid && !flush && (!st_valid || starve_cnt == CNT_MAX)) begin
                grant_ld = 1'b1;
            end else if (st_valid) begin
                grant_st = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_ld) begin
                    state_next = LD_BUSY;
                end else if (grant_st) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dc_ufp_resp) begin
                    state_next = IDLE;
                end
            end
            LD_BUSY: begin
                // A flush coinciding with the response drops it and frees
                // the port immediately; otherwise the in-flight access
                // must be drained before the port can be reused.
                if (dc_ufp_resp) begin
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                if (dc_ufp_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_q      <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (grant_ld) begin
                req_q      <= ld_req;
                starve_cnt <= '0;
            end else if (grant_st) begin
                req_q <= st_req;
                if (!ld_valid) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    // The request is withdrawn in the response cycle so the cache does not
    // see it again while the arbiter returns to IDLE.
    always_comb begin
        dc_ufp_out = '0;
        if (state != IDLE && !dc_ufp_resp) begin
            dc_ufp_out = req_q;
        end
    end

    assign st_resp  = (state == ST_BUSY) && dc_ufp_resp;
    assign ld_resp  = (state == LD_BUSY) && dc_ufp_resp && !flush;
    assign ld_rdata = ld_resp ? dc_ufp_rdata : 32'd0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
    import rv32i_types::*;

    logic             clk;
    logic             rst;
    logic             flush;
    cache_interface_t st_req;
    cache_interface_t ld_req;
    logic             dc_ufp_resp;
    logic [31:0]      dc_ufp_rdata;
    cache_interface_t dc_ufp_out;
    logic             st_resp;
    logic             ld_resp;
    logic [31:0]      ld_rdata;
    logic             busy;

    int checks = 0;
    int errors = 0;

    dcache_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .st_req       (st_req),
        .ld_req       (ld_req),
        .dc_ufp_resp  (dc_ufp_resp),
        .dc_ufp_rdata (dc_ufp_rdata),
        .dc_ufp_out   (dc_ufp_out),
        .st_resp      (st_resp),
        .ld_resp      (ld_resp),
        .ld_rdata     (ld_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam cache_interface_t ST_A = '{ufp_addr: 32'h0000_1000, ufp_rmask: 4'h0,
                                          ufp_wmask: 4'hF, ufp_wdata: 32'hDEAD_BEEF};
    localparam cache_interface_t LD_A = '{ufp_addr: 32'h0000_2004, ufp_rmask: 4'hF,
                                          ufp_wmask: 4'h0, ufp_wdata: 32'h0};

    typedef struct {
        logic        st_v;
        logic        ld_v;
        logic        fl;
        logic        rsp;
        logic [31:0] rdata;
        logic [1:0]  out_sel;   // 0 none, 1 ST_A, 2 LD_A
        logic        e_st_resp;
        logic        e_ld_resp;
        logic [31:0] e_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st_v, input logic ld_v, input logic fl, input logic rsp,
                       input logic [31:0] rdata, input logic [1:0] out_sel,
                       input logic e_st, input logic e_ld, input logic [31:0] e_rd,
                       input logic e_busy);
        vec_t v;
        v.st_v = st_v; v.ld_v = ld_v; v.fl = fl; v.rsp = rsp; v.rdata = rdata;
        v.out_sel = out_sel; v.e_st_resp = e_st; v.e_ld_resp = e_ld;
        v.e_rdata = e_rd; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; st_req = '0; ld_req = '0; dc_ufp_resp = 1'b0; dc_ufp_rdata = '0;
    endtask

    initial begin
        cache_interface_t exp_out;
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 72'(dc_ufp_out), 72'h0);
        chk("reset_busy", 72'(busy), 72'h0);
        chk("reset_cnt", 72'(dut.starve_cnt), 72'h0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // lone store: granted at 0, on the port 1..2, response at 3
        add(1,0,0,0,0,           0,0,0,0,0);
        add(1,0,0,0,0,           1,0,0,0,1);
        add(1,0,0,0,0,           1,0,0,0,1);
        add(0,0,0,1,0,           0,1,0,0,1);
        // response while idle is ignored
        add(0,0,0,1,32'h1111_2222, 0,0,0,0,0);
        // lone load
        add(0,1,0,0,0,           0,0,0,0,0);
        add(0,1,0,0,0,           2,0,0,0,1);
        add(0,0,0,1,32'h1234_5678, 0,0,1,32'h1234_5678,1);
        add(0,0,0,0,0,           0,0,0,0,0);
        // flush and load response together: dropped
        add(0,1,0,0,0,           0,0,0,0,0);
        add(0,1,1,1,32'hAAAA_5555, 0,0,0,0,1);
        add(0,0,0,0,0,           0,0,0,0,0);
        // flush and store response together: store still completes
        add(1,0,0,0,0,           0,0,0,0,0);
        add(0,0,1,1,0,           0,1,0,0,1);
        add(0,0,0,0,0,           0,0,0,0,0);
        // flush in IDLE blocks a load grant
        add(0,1,1,0,0,           0,0,0,0,0);
        add(0,1,0,0,0,           0,0,0,0,0);
        add(0,1,0,0,0,           2,0,0,0,1);
        add(0,0,0,1,32'h0BAD_F00D, 0,0,1,32'h0BAD_F00D,1);
        add(0,0,0,0,0,           0,0,0,0,0);
        // store beats load with an empty counter, then the load goes next
        add(1,1,0,0,0,           0,0,0,0,0);
        add(1,1,0,0,0,           1,0,0,0,1);
        add(0,1,0,1,0,           0,1,0,0,1);
        add(0,1,0,0,0,           0,0,0,0,0);
        add(0,1,0,0,0,           2,0,0,0,1);
        add(0,0,0,1,32'h0000_0001, 0,0,1,32'h0000_0001,1);
        add(0,0,0,0,0,           0,0,0,0,0);

        foreach (vecs[i]) begin
            st_req       = vecs[i].st_v ? ST_A : '0;
            ld_req       = vecs[i].ld_v ? LD_A : '0;
            flush        = vecs[i].fl;
            dc_ufp_resp  = vecs[i].rsp;
            dc_ufp_rdata = vecs[i].rdata;
            exp_out = (vecs[i].out_sel == 2'd1) ? ST_A : (vecs[i].out_sel == 2'd2) ? LD_A : '0;
            @(negedge clk);
            chk($sformatf("v%0d_out", i), 72'(dc_ufp_out), 72'(exp_out));
            chk($sformatf("v%0d_st_resp", i), 72'(st_resp), 72'(vecs[i].e_st_resp));
            chk($sformatf("v%0d_ld_resp", i), 72'(ld_resp), 72'(vecs[i].e_ld_resp));
            chk($sformatf("v%0d_ld_rdata", i), 72'(ld_rdata), 72'(vecs[i].e_rdata));
            chk($sformatf("v%0d_busy", i), 72'(busy), 72'(vecs[i].e_busy));
            next_cycle();
        end
        clear_inputs();
        next_cycle();

        // anti-starvation: load held, store offered every window
        ld_req = LD_A;
        for (int i = 0; i < 5; i++) begin
            st_req = ST_A;
            st_req.ufp_wdata = 32'(i);
            next_cycle();
            @(negedge clk);
            if (i < 4) begin
                chk($sformatf("starve%0d_store_won", i), 72'(dc_ufp_out.ufp_wmask), 72'hF);
                chk($sformatf("starve%0d_cnt", i), 72'(dut.starve_cnt), 72'(i + 1));
            end else begin
                chk("starve_load_won", 72'(dc_ufp_out), 72'(LD_A));
                chk("starve_cnt_cleared", 72'(dut.starve_cnt), 72'h0);
            end
            next_cycle();
            dc_ufp_resp = 1'b1;
            dc_ufp_rdata = 32'hCAFE_0000;
            if (i < 4) st_req = '0;
            else ld_req = '0;
            @(negedge clk);
            if (i < 4) chk($sformatf("starve%0d_st_resp", i), 72'(st_resp), 72'h1);
            else       chk("starve_ld_resp", 72'(ld_rdata), 72'hCAFE_0000);
            next_cycle();
            dc_ufp_resp = 1'b0;
        end
        clear_inputs();
        next_cycle();

        // flush one cycle after load grant, response three cycles later
        ld_req = LD_A;
        next_cycle();
        ld_req = '0;
        flush  = 1'b1;
        st_req = ST_A;
        @(negedge clk);
        chk("drain_ld_busy", 72'(dut.state), 72'(LD_BUSY));
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("drain_state", 72'(dut.state), 72'(LD_DRAIN));
        chk("drain_out", 72'(dc_ufp_out), 72'(LD_A));
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("drain_reflush_state", 72'(dut.state), 72'(LD_DRAIN));
        next_cycle();
        flush = 1'b0;
        dc_ufp_resp = 1'b1;
        dc_ufp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("drain_ld_resp", 72'(ld_resp), 72'h0);
        chk("drain_ld_rdata", 72'(ld_rdata), 72'h0);
        chk("drain_st_resp", 72'(st_resp), 72'h0);
        chk("drain_resp_out", 72'(dc_ufp_out), 72'h0);
        next_cycle();
        dc_ufp_resp = 1'b0;
        @(negedge clk);
        chk("drain_idle", 72'(dut.state), 72'(IDLE));
        next_cycle();
        @(negedge clk);
        chk("drain_store_granted", 72'(dut.state), 72'(ST_BUSY));
        chk("drain_store_out", 72'(dc_ufp_out), 72'(ST_A));
        next_cycle();
        st_req = '0;
        dc_ufp_resp = 1'b1;
        @(negedge clk);
        chk("drain_store_resp", 72'(st_resp), 72'h1);
        next_cycle();
        clear_inputs();
        next_cycle();

        // asynchronous reset in the middle of a load
        ld_req = LD_A;
        next_cycle();
        ld_req = '0;
        @(negedge clk);
        chk("rst_pre_state", 72'(dut.state), 72'(LD_BUSY));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_out", 72'(dc_ufp_out), 72'h0);
        chk("rst_async_busy", 72'(busy), 72'h0);
        chk("rst_async_state", 72'(dut.state), 72'(IDLE));
        chk("rst_async_ld_resp", 72'(ld_resp), 72'h0);
        next_cycle();
        rst = 1'b1;
        dc_ufp_resp = 1'b1;
        dc_ufp_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("rst_stale_ld_resp", 72'(ld_resp), 72'h0);
        chk("rst_stale_ld_rdata", 72'(ld_rdata), 72'h0);
        chk("rst_stale_busy", 72'(busy), 72'h0);
        next_cycle();
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
